sprite_layer_scheduler: RTL
===========================

Name: sprite_layer_scheduler

Overview:
- Per-pixel compositor and sequencer for the sprite ROM set: 4 characters, 4 projectiles and the battle arena background.
- For each requested OLED pixel it walks the object layers in priority order and issues lookups on one shared sprite-fetch port.
- The first non-transparent sprite pixel wins; the arena pixel is the fallback.
- It sits between the OLED pixel-index driver and the sprite ROM mux.

Parameters:
- NUM_OBJ, 8, number of object slots; slot 0 has highest priority.
- SPRITE_W, 20, sprite width in pixels.
- SPRITE_H, 20, sprite height in pixels.
- TRANSPARENT, 18'h00001, ROM word treated as "no pixel".
- ARENA_SEL, 8, fetch_sel code for the arena ROM.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  pixel request strobe; source holds it until accepted
- req_ready  out  1  high when the block can accept a request
- req_x  in  7  screen x, 0..95
- req_y  in  6  screen y, 0..63
- obj_en  in  NUM_OBJ  per-slot enable
- obj_x  in  7*NUM_OBJ  per-slot top-left x; slot i at [7i+6:7i]
- obj_y  in  6*NUM_OBJ  per-slot top-left y
- obj_dir  in  2*NUM_OBJ  per-slot direction, selects 1 of 4 frames
- fetch_en  out  1  lookup strobe
- fetch_sel  out  4  ROM select: 0..NUM_OBJ-1 = slot, ARENA_SEL = arena
- fetch_x  out  10  local x into the selected ROM
- fetch_y  out  10  local y into the selected ROM
- fetch_dir  out  2  frame select
- fetch_data  in  18  ROM word, valid one cycle after fetch_en
- pix_valid  out  1  one-cycle result pulse
- pix_data  out  18  composited pixel

Behaviour:
- Reset (asynchronous, any time including mid-scan):
  - state=IDLE, idx=0, all latches=0.
  - pix_valid=0, pix_data=0, fetch_en=0, fetch_sel/x/y/dir=0, req_ready=1 once reset is released.
- req_ready = (state==IDLE).
  - Acceptance occurs at the edge where req_valid&&req_ready.
  - At acceptance, latch req_x/y and snapshot obj_en/x/y/dir.
  - Input changes during a scan are ignored.
- States: IDLE, PROBE, WAIT.
- IDLE:
  - On acceptance: idx<=0, state<=PROBE.
  - pix_valid is high only in the cycle after a WAIT completes; the block is then already in IDLE and can accept a new request in that same cycle.
- PROBE(idx<NUM_OBJ):
  - Hit test: obj_en[idx] && req_x>=obj_x && (req_x-obj_x)<SPRITE_W && req_y>=obj_y && (req_y-obj_y)<SPRITE_H. Unsigned compare; no wrap, so an object partially off the right or bottom edge still hits its visible pixels.
  - On hit:
    - fetch_en=1, fetch_sel=idx, fetch_x/y = req minus obj, zero-extended to 10 bits, fetch_dir=obj_dir[idx]. These are combinational from registered state.
    - Next state WAIT.
  - On miss: fetch_en=0, idx<=idx+1, stay in PROBE. Exactly one cycle per missed slot.
- PROBE(idx==NUM_OBJ), arena:
  - fetch_en=1, fetch_sel=ARENA_SEL, fetch_x/y = req_x/req_y zero-extended, fetch_dir=0.
  - Next state WAIT.
- WAIT:
  - fetch_data is valid in this cycle; fetch_en=0.
  - If idx==NUM_OBJ, or fetch_data!=TRANSPARENT: register pix_data<=fetch_data and pix_valid<=1, state<=IDLE.
  - Otherwise: idx<=idx+1, state<=PROBE. A transparent sprite pixel falls through to lower layers.
- Arena result is never tested for transparency; it is always output.
- pix_valid clears after one cycle; pix_data holds its value until the next result.
- Latency, counted from the acceptance edge to the pix_valid cycle:
  - 3 cycles when slot 0 hits opaque.
  - 11 cycles when all 8 slots miss.
  - Worst case 19 cycles, when all 8 slots hit transparent.
- Overlapping objects: the lowest index wins. Disabled slots never fetch.

Test Plan:
- Reset, then no request: req_ready=1, pix_valid=0, fetch_en never asserted.
- All obj_en=0; request (10,10); arena ROM returns 18'h2AAAA: fetch_sel=8 with x=10, y=10; pix_valid in cycle 11 with pix_data=18'h2AAAA.
- Slot 0 enabled at (5,5), dir=2; request (7,9); ROM returns 18'h3F000: fetch_sel=0, x=2, y=4, dir=2; pix_valid at cycle 3 with 18'h3F000.
- Slots 1 and 4 both cover the pixel; slot 1 word=TRANSPARENT, slot 4 word=18'h00F0F: fetches go to slot 1 then slot 4; output 18'h00F0F; arena never fetched.
- Slot 3 at (90,60); requests (95,63) and (89,63): the first hits with local (5,3); the second misses and falls to the arena.
- Assert reset during WAIT: state returns to IDLE, pix_valid stays 0. A subsequent request completes normally.

Source files
------------

// File: rtl/sprite_layer_scheduler.sv
// sprite_layer_scheduler
//   Per-pixel compositor for the sprite ROM set (object slots plus arena
//   background). Each accepted OLED pixel request walks the object slots in
//   priority order (slot 0 first). For every slot whose sprite covers the
//   pixel, it issues one lookup on the shared sprite-fetch port. The first
//   non-transparent word wins. If no slot supplies a word, the arena pixel
//   is fetched and output unconditionally.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   req_valid/req_ready   pixel request handshake; req_x/req_y = screen pixel
//   obj_en/x/y/dir        per-slot object state, snapshotted at acceptance
//   fetch_en/sel/x/y/dir  lookup strobe toward the sprite ROM mux
//   fetch_data            ROM word, valid the cycle after fetch_en
//   pix_valid/pix_data    one-cycle result pulse and held composited pixel
module sprite_layer_scheduler #(
  parameter int          NUM_OBJ     = 8,
  parameter int          SPRITE_W    = 20,
  parameter int          SPRITE_H    = 20,
  parameter logic [17:0] TRANSPARENT = 18'h00001,
  parameter int          ARENA_SEL   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [6:0]           req_x,
  input  logic [5:0]           req_y,
  input  logic [NUM_OBJ-1:0]   obj_en,
  input  logic [7*NUM_OBJ-1:0] obj_x,
  input  logic [6*NUM_OBJ-1:0] obj_y,
  input  logic [2*NUM_OBJ-1:0] obj_dir,
  output logic                 fetch_en,
  output logic [3:0]           fetch_sel,
  output logic [9:0]           fetch_x,
  output logic [9:0]           fetch_y,
  output logic [1:0]           fetch_dir,
  input  logic [17:0]          fetch_data,
  output logic                 pix_valid,
  output logic [17:0]          pix_data
);

  // The index runs one past the last slot; that extra value means "arena".
  localparam int IDX_W  = $clog2(NUM_OBJ + 1);
  localparam int SLOT_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  typedef enum logic [1:0] {IDLE, PROBE, WAIT} state_t;

  state_t               r_state, w_nextState;
  logic [IDX_W-1:0]     r_idx, w_nextIdx;
  logic [6:0]           r_reqX;
  logic [5:0]           r_reqY;
  logic [NUM_OBJ-1:0]   r_objEn;
  logic [7*NUM_OBJ-1:0] r_objX;
  logic [6*NUM_OBJ-1:0] r_objY;
  logic [2*NUM_OBJ-1:0] r_objDir;

  logic [SLOT_W-1:0]    w_slot;
  logic                 w_objEn;
  logic [6:0]           w_objX;
  logic [5:0]           w_objY;
  logic [1:0]           w_objDir;
  logic [6:0]           w_dx;
  logic [5:0]           w_dy;
  logic                 w_hit;
  logic                 w_atArena;
  logic                 w_pixLoad;

  // Slot-select mux. When r_idx is at the arena value, w_slot aliases a
  // real slot. The resulting hit is ignored because w_atArena takes precedence.
  assign w_slot    = r_idx[SLOT_W-1:0];
  assign w_atArena = (r_idx == IDX_W'(NUM_OBJ));
  assign w_objEn   = r_objEn[w_slot];
  assign w_objX    = r_objX[7*w_slot +: 7];
  assign w_objY    = r_objY[6*w_slot +: 6];
  assign w_objDir  = r_objDir[2*w_slot +: 2];

  // Offsets are only meaningful when req >= obj. The >= terms gate that,
  // so a sprite hanging off the right or bottom edge still hits its
  // visible pixels without wrap-around.
  assign w_dx  = r_reqX - w_objX;
  assign w_dy  = r_reqY - w_objY;
  assign w_hit = w_objEn
              && (r_reqX >= w_objX) && (w_dx < 7'(SPRITE_W))
              && (r_reqY >= w_objY) && (w_dy < 6'(SPRITE_H));

  // Next-state and fetch-port decode. The fetch port is driven purely from
  // registered state, so the ROM mux sees a stable address for the whole
  // PROBE cycle.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_pixLoad   = 1'b0;
    req_ready   = 1'b0;
    fetch_en    = 1'b0;
    fetch_sel   = 4'd0;
    fetch_x     = 10'd0;
    fetch_y     = 10'd0;
    fetch_dir   = 2'd0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_nextIdx   = '0;
          w_nextState = PROBE;
        end
      end
      PROBE: begin
        if (w_atArena) begin
          fetch_en    = 1'b1;
          fetch_sel   = 4'(ARENA_SEL);
          fetch_x     = {3'd0, r_reqX};
          fetch_y     = {4'd0, r_reqY};
          w_nextState = WAIT;
        end else if (w_hit) begin
          fetch_en    = 1'b1;
          fetch_sel   = 4'(r_idx);
          fetch_x     = {3'd0, w_dx};
          fetch_y     = {4'd0, w_dy};
          fetch_dir   = w_objDir;
          w_nextState = WAIT;
        end else begin
          w_nextIdx = r_idx + IDX_W'(1);
        end
      end
      WAIT: begin
        // The arena word is the fallback and is never treated as transparent.
        if (w_atArena || (fetch_data != TRANSPARENT)) begin
          w_pixLoad   = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_nextIdx   = r_idx + IDX_W'(1);
          w_nextState = PROBE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State, scan index and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      pix_valid <= 1'b0;
      pix_data  <= 18'd0;
    end else begin
      r_state   <= w_nextState;
      r_idx     <= w_nextIdx;
      pix_valid <= w_pixLoad;
      if (w_pixLoad) begin
        pix_data <= fetch_data;
      end
    end
  end

  // Request and object snapshot. Input changes during a scan must not
  // disturb the pixel being composited.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reqX   <= 7'd0;
      r_reqY   <= 6'd0;
      r_objEn  <= '0;
      r_objX   <= '0;
      r_objY   <= '0;
      r_objDir <= '0;
    end else if (req_valid && req_ready) begin
      r_reqX   <= req_x;
      r_reqY   <= req_y;
      r_objEn  <= obj_en;
      r_objX   <= obj_x;
      r_objY   <= obj_y;
      r_objDir <= obj_dir;
    end
  end

endmodule
